// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: event inputs from EX/DEC/MEM plus the pipeline enables,
// flushes, PC redirect and performance counters returned to the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned CNT_BITS = 16
);
    logic                mispredict;
    logic [DBITS-1:0]    redirect_pc;
    logic                load_use;
    logic                mem_busy;
    logic                pc_we;
    logic                pc_sel;
    logic [DBITS-1:0]    pc_redirect;
    logic                if_dec_en;
    logic                if_dec_flush;
    logic                dec_ex_en;
    logic                dec_ex_flush;
    logic                ex_mem_en;
    logic [CNT_BITS-1:0] mispredict_cnt;
    logic [CNT_BITS-1:0] stall_cnt;

    modport master (
        output mispredict, redirect_pc, load_use, mem_busy,
        input  pc_we, pc_sel, pc_redirect, if_dec_en, if_dec_flush,
               dec_ex_en, dec_ex_flush, ex_mem_en, mispredict_cnt, stall_cnt
    );

    modport slave (
        input  mispredict, redirect_pc, load_use, mem_busy,
        output pc_we, pc_sel, pc_redirect, if_dec_en, if_dec_flush,
               dec_ex_en, dec_ex_flush, ex_mem_en, mispredict_cnt, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: arbitrates memory freezes, branch redirects and
// load-use bubbles; Mealy control outputs, registered state and counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned DBITS             = 32,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_BITS          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   bus
);

    localparam int unsigned SL_BITS = 4;
    localparam logic [SL_BITS-1:0] STALL_INIT = SL_BITS'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SL_BITS-1:0]  stall_left_q, stall_left_d;
    logic                pend_valid_q, pend_valid_d;
    logic [DBITS-1:0]    pend_pc_q, pend_pc_d;
    logic [CNT_BITS-1:0] mispredict_cnt_q, stall_cnt_q;
    logic                mis_inc;

    logic             pc_we_c, pc_sel_c;
    logic [DBITS-1:0] pc_redirect_c;
    logic             if_dec_en_c, if_dec_flush_c, dec_ex_en_c, dec_ex_flush_c, ex_mem_en_c;

    // Next-state and Mealy control decode
    always_comb begin
        state_d        = state_q;
        stall_left_d   = stall_left_q;
        pend_valid_d   = pend_valid_q;
        pend_pc_d      = pend_pc_q;
        mis_inc        = 1'b0;
        pc_we_c        = 1'b1;
        pc_sel_c       = 1'b0;
        pc_redirect_c  = bus.redirect_pc;
        if_dec_en_c    = 1'b1;
        if_dec_flush_c = 1'b0;
        dec_ex_en_c    = 1'b1;
        dec_ex_flush_c = 1'b0;
        ex_mem_en_c    = 1'b1;

        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (bus.mem_busy) begin
                    pc_we_c     = 1'b0;
                    if_dec_en_c = 1'b0;
                    dec_ex_en_c = 1'b0;
                    ex_mem_en_c = 1'b0;
                    // Branch resolved while frozen: park the target until memory frees
                    if (bus.mispredict) begin
                        pend_pc_d    = bus.redirect_pc;
                        pend_valid_d = 1'b1;
                        stall_left_d = '0;
                        state_d      = ST_HOLD;
                    end
                end else if (bus.mispredict) begin
                    pc_sel_c       = 1'b1;
                    if_dec_flush_c = 1'b1;
                    dec_ex_flush_c = 1'b1;
                    mis_inc        = 1'b1;
                    stall_left_d   = '0;
                    state_d        = ST_RUN;
                end else if (state_q == ST_STALL || bus.load_use) begin
                    pc_we_c        = 1'b0;
                    if_dec_en_c    = 1'b0;
                    dec_ex_flush_c = 1'b1;
                    if (state_q == ST_RUN) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            stall_left_d = STALL_INIT;
                            state_d      = ST_STALL;
                        end
                    end else if (stall_left_q == SL_BITS'(1)) begin
                        stall_left_d = '0;
                        state_d      = ST_RUN;
                    end else begin
                        stall_left_d = stall_left_q - SL_BITS'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.mem_busy) begin
                    pc_we_c     = 1'b0;
                    if_dec_en_c = 1'b0;
                    dec_ex_en_c = 1'b0;
                    ex_mem_en_c = 1'b0;
                end else begin
                    if (pend_valid_q) begin
                        pc_sel_c       = 1'b1;
                        pc_redirect_c  = pend_pc_q;
                        if_dec_flush_c = 1'b1;
                        dec_ex_flush_c = 1'b1;
                        mis_inc        = 1'b1;
                    end
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Reset holds the whole pipe cleared regardless of state
        if (reset) begin
            pc_we_c        = 1'b0;
            pc_sel_c       = 1'b0;
            pc_redirect_c  = '0;
            if_dec_en_c    = 1'b0;
            if_dec_flush_c = 1'b1;
            dec_ex_en_c    = 1'b0;
            dec_ex_flush_c = 1'b1;
            ex_mem_en_c    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            stall_left_q     <= '0;
            pend_valid_q     <= 1'b0;
            pend_pc_q        <= '0;
            mispredict_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            // Saturating performance counters
            if (mis_inc && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + CNT_BITS'(1);
            if (!pc_we_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
        end
    end

    assign bus.pc_we          = pc_we_c;
    assign bus.pc_sel         = pc_sel_c;
    assign bus.pc_redirect    = pc_redirect_c;
    assign bus.if_dec_en      = if_dec_en_c;
    assign bus.if_dec_flush   = if_dec_flush_c;
    assign bus.dec_ex_en      = dec_ex_en_c;
    assign bus.dec_ex_flush   = dec_ex_flush_c;
    assign bus.ex_mem_en      = ex_mem_en_c;
    assign bus.mispredict_cnt = mispredict_cnt_q;
    assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances cover stall
// lengths 2 and 3 and a 4-bit counter variant for saturation.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;

    // {pc_we, pc_sel, if_dec_en, if_dec_flush, dec_ex_en, dec_ex_flush, ex_mem_en}
    localparam logic [6:0] C_NORMAL = 7'b1010101;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_BUBBLE = 7'b0000111;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_RESET  = 7'b0001010;

    int n_chk  = 0;
    int n_pass = 0;

    pipeline_hazard_ctrl_if #(.DBITS(32), .CNT_BITS(16)) ia ();
    pipeline_hazard_ctrl_if #(.DBITS(32), .CNT_BITS(16)) ib ();
    pipeline_hazard_ctrl_if #(.DBITS(32), .CNT_BITS(4))  ic ();

    pipeline_hazard_ctrl #(.DBITS(32), .LOAD_STALL_CYCLES(2), .CNT_BITS(16)) u_a (
        .clk(clk), .reset(reset), .bus(ia));
    pipeline_hazard_ctrl #(.DBITS(32), .LOAD_STALL_CYCLES(3), .CNT_BITS(16)) u_b (
        .clk(clk), .reset(reset), .bus(ib));
    pipeline_hazard_ctrl #(.DBITS(32), .LOAD_STALL_CYCLES(1), .CNT_BITS(4)) u_c (
        .clk(clk), .reset(reset), .bus(ic));

    logic [6:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {ia.pc_we, ia.pc_sel, ia.if_dec_en, ia.if_dec_flush, ia.dec_ex_en, ia.dec_ex_flush, ia.ex_mem_en};
    assign ctl_b = {ib.pc_we, ib.pc_sel, ib.if_dec_en, ib.if_dec_flush, ib.dec_ex_en, ib.dec_ex_flush, ib.ex_mem_en};
    assign ctl_c = {ic.pc_we, ic.pc_sel, ic.if_dec_en, ic.if_dec_flush, ic.dec_ex_en, ic.dec_ex_flush, ic.ex_mem_en};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ia.mispredict = 1'b0; ia.redirect_pc = 32'h55; ia.load_use = 1'b0; ia.mem_busy = 1'b0;
        ib.mispredict = 1'b0; ib.redirect_pc = 32'h0;  ib.load_use = 1'b0; ib.mem_busy = 1'b0;
        ic.mispredict = 1'b0; ic.redirect_pc = 32'h0;  ic.load_use = 1'b0; ic.mem_busy = 1'b0;

        // Reset: outputs forced, counters cleared
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            check("reset_ctl", 32'(ctl_a), 32'(C_RESET));
        end
        check("reset_redir_pc", ia.pc_redirect, 32'h0);
        check("reset_mcnt", 32'(ia.mispredict_cnt), 32'd0);
        check("reset_scnt", 32'(ia.stall_cnt), 32'd0);

        next_cycle(); reset = 1'b0; ia.redirect_pc = 32'h0; settle();
        for (int i = 0; i < 5; i++) begin
            check("normal_ctl", 32'(ctl_a), 32'(C_NORMAL));
            next_cycle(); settle();
        end
        check("normal_mcnt", 32'(ia.mispredict_cnt), 32'd0);
        check("normal_scnt", 32'(ia.stall_cnt), 32'd0);

        // Single mispredict redirect
        ia.mispredict = 1'b1; ia.redirect_pc = 32'h0000_0040; settle();
        check("mp_ctl", 32'(ctl_a), 32'(C_REDIR));
        check("mp_pc", ia.pc_redirect, 32'h40);
        next_cycle(); ia.mispredict = 1'b0; settle();
        check("mp_after_ctl", 32'(ctl_a), 32'(C_NORMAL));
        check("mp_mcnt", 32'(ia.mispredict_cnt), 32'd1);

        // Load-use, two bubbles
        next_cycle(); ia.load_use = 1'b1; settle();
        check("lu_b1", 32'(ctl_a), 32'(C_BUBBLE));
        next_cycle(); ia.load_use = 1'b0; settle();
        check("lu_b2", 32'(ctl_a), 32'(C_BUBBLE));
        next_cycle(); settle();
        check("lu_done", 32'(ctl_a), 32'(C_NORMAL));
        check("lu_scnt", 32'(ia.stall_cnt), 32'd2);

        // Load-use with a 3-cycle freeze during the second bubble: 2 + 5 = 7
        next_cycle(); ia.load_use = 1'b1; settle();
        check("luf_b1", 32'(ctl_a), 32'(C_BUBBLE));
        next_cycle(); ia.load_use = 1'b0; ia.mem_busy = 1'b1; settle();
        for (int i = 0; i < 3; i++) begin
            check("luf_freeze", 32'(ctl_a), 32'(C_FREEZE));
            next_cycle(); settle();
        end
        ia.mem_busy = 1'b0; settle();
        check("luf_b2", 32'(ctl_a), 32'(C_BUBBLE));
        next_cycle(); settle();
        check("luf_done", 32'(ctl_a), 32'(C_NORMAL));
        check("luf_scnt", 32'(ia.stall_cnt), 32'd7);

        // Mispredict under freeze is parked and applied once with the held target
        next_cycle(); ia.mem_busy = 1'b1; ia.mispredict = 1'b1; ia.redirect_pc = 32'h100; settle();
        for (int i = 0; i < 4; i++) begin
            check("hold_freeze", 32'(ctl_a), 32'(C_FREEZE));
            next_cycle(); settle();
        end
        ia.mem_busy = 1'b0; ia.mispredict = 1'b0; ia.redirect_pc = 32'h200; settle();
        check("hold_redir_ctl", 32'(ctl_a), 32'(C_REDIR));
        check("hold_redir_pc", ia.pc_redirect, 32'h100);
        next_cycle(); settle();
        check("hold_after", 32'(ctl_a), 32'(C_NORMAL));
        check("hold_mcnt", 32'(ia.mispredict_cnt), 32'd2);
        check("hold_scnt", 32'(ia.stall_cnt), 32'd11);

        // Three-cycle stall; load_use held high is ignored inside the stall
        ib.load_use = 1'b1; settle();
        check("b_b1", 32'(ctl_b), 32'(C_BUBBLE));
        next_cycle(); settle();
        check("b_b2", 32'(ctl_b), 32'(C_BUBBLE));
        next_cycle(); settle();
        check("b_b3", 32'(ctl_b), 32'(C_BUBBLE));
        next_cycle(); ib.load_use = 1'b0; settle();
        check("b_done", 32'(ctl_b), 32'(C_NORMAL));
        check("b_scnt", 32'(ib.stall_cnt), 32'd3);

        // Mispredict on second bubble aborts the stall
        next_cycle(); ib.load_use = 1'b1; settle();
        check("bm_b1", 32'(ctl_b), 32'(C_BUBBLE));
        next_cycle(); ib.load_use = 1'b0; ib.mispredict = 1'b1; ib.redirect_pc = 32'h80; settle();
        check("bm_redir_ctl", 32'(ctl_b), 32'(C_REDIR));
        check("bm_redir_pc", ib.pc_redirect, 32'h80);
        next_cycle(); ib.mispredict = 1'b0; settle();
        check("bm_no_b3", 32'(ctl_b), 32'(C_NORMAL));
        check("bm_mcnt", 32'(ib.mispredict_cnt), 32'd1);
        check("bm_scnt", 32'(ib.stall_cnt), 32'd4);

        // Reset while a redirect is pending discards it
        next_cycle(); ic.mem_busy = 1'b1; ic.mispredict = 1'b1; ic.redirect_pc = 32'h300; settle();
        check("c_hold_freeze", 32'(ctl_c), 32'(C_FREEZE));
        next_cycle(); ic.mispredict = 1'b0; reset = 1'b1; settle();
        check("c_reset_ctl", 32'(ctl_c), 32'(C_RESET));
        next_cycle(); reset = 1'b0; ic.mem_busy = 1'b0; settle();
        check("c_no_redir", 32'(ctl_c), 32'(C_NORMAL));
        check("c_mcnt0", 32'(ic.mispredict_cnt), 32'd0);
        check("c_scnt0", 32'(ic.stall_cnt), 32'd0);
        check("a_mcnt_reset", 32'(ia.mispredict_cnt), 32'd0);

        // Single-cycle stall configuration
        next_cycle(); ic.load_use = 1'b1; settle();
        check("c_bubble", 32'(ctl_c), 32'(C_BUBBLE));
        next_cycle(); ic.load_use = 1'b0; settle();
        check("c_bubble_done", 32'(ctl_c), 32'(C_NORMAL));
        check("c_scnt1", 32'(ic.stall_cnt), 32'd1);

        // Counter saturation with 4-bit counters
        ic.mispredict = 1'b1; ic.redirect_pc = 32'h400;
        for (int i = 0; i < 20; i++) begin
            settle();
            check("c_sat_ctl", 32'(ctl_c), 32'(C_REDIR));
            if (i == 15) check("c_mcnt15", 32'(ic.mispredict_cnt), 32'd15);
            next_cycle();
        end
        ic.mispredict = 1'b0; settle();
        check("c_mcnt_sat", 32'(ic.mispredict_cnt), 32'd15);
        check("c_scnt_kept", 32'(ic.stall_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
